// File: rtl/lcd_scanline_fx.sv
// lcd_scanline_fx: darkens odd scanlines by a per-frame mode, delays syncs to match, measures lines/frame and flags lock.
// Latency: PIPE_LAT (2) pce cycles from input pixel to output pixel; outputs hold between pce pulses.
// Backpressure: none; the video stream is free-running and advances only on pce.
module lcd_scanline_fx #(
  parameter int PIPE_LAT = 2,
  parameter int LCNT_W   = 9
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              pce,
  input  logic [1:0]        mode,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic              blank_in,
  input  logic [7:0]        r_in,
  input  logic [7:0]        g_in,
  input  logic [7:0]        b_in,
  output logic              hs,
  output logic              vs,
  output logic              blank,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b,
  output logic [LCNT_W-1:0] frame_lines,
  output logic              locked
);

  // The pipeline below is hard-wired to two stages; catch a mismatched override early.
  if (PIPE_LAT != 2) begin : g_bad_lat
    $error("lcd_scanline_fx: PIPE_LAT must be 2");
  end

  logic              hs_prev;
  logic              vs_prev;
  logic              parity;
  logic [LCNT_W-1:0] line_cnt;
  logic [1:0]        act_mode;
  logic              hs_rise;
  logic              vs_rise;

  logic              s1_hs;
  logic              s1_vs;
  logic              s1_blank;
  logic              s1_par;
  logic [7:0]        s1_r;
  logic [7:0]        s1_g;
  logic [7:0]        s1_b;

  assign hs_rise = hs_in & ~hs_prev;
  assign vs_rise = vs_in & ~vs_prev;

  function automatic logic [7:0] darken(input logic [7:0] x, input logic [1:0] m);
    logic [7:0] y;
    case (m)
      2'd1:    y = x - {2'b00, x[7:2]};
      2'd2:    y = {1'b0, x[7:1]};
      2'd3:    y = {2'b00, x[7:2]};
      default: y = x;
    endcase
    return y;
  endfunction

  // Edge history, line parity/count, per-frame measurement and mode latch; vs_rise beats hs_rise.
  always_ff @(posedge pclk) begin
    if (reset) begin
      hs_prev     <= 1'b0;
      vs_prev     <= 1'b0;
      parity      <= 1'b0;
      line_cnt    <= '0;
      act_mode    <= 2'd0;
      frame_lines <= '0;
      locked      <= 1'b0;
    end else if (pce) begin
      hs_prev <= hs_in;
      vs_prev <= vs_in;
      if (vs_rise) begin
        parity      <= 1'b0;
        line_cnt    <= '0;
        frame_lines <= line_cnt;
        locked      <= (line_cnt == frame_lines) && (frame_lines != '0);
        act_mode    <= mode;
      end else if (hs_rise) begin
        parity <= ~parity;
        if (line_cnt != {LCNT_W{1'b1}}) begin
          line_cnt <= line_cnt + LCNT_W'(1);
        end
      end
    end
  end

  // Stage 1: capture syncs, blank, pixel and the parity of the line it belongs to.
  always_ff @(posedge pclk) begin
    if (reset) begin
      s1_hs    <= 1'b0;
      s1_vs    <= 1'b0;
      s1_blank <= 1'b1;
      s1_par   <= 1'b0;
      s1_r     <= 8'h00;
      s1_g     <= 8'h00;
      s1_b     <= 8'h00;
    end else if (pce) begin
      s1_hs    <= hs_in;
      s1_vs    <= vs_in;
      s1_blank <= blank_in;
      s1_par   <= parity;
      s1_r     <= r_in;
      s1_g     <= g_in;
      s1_b     <= b_in;
    end
  end

  // Stage 2: blanking forces black, odd lines get darkened, even lines pass through.
  always_ff @(posedge pclk) begin
    if (reset) begin
      hs    <= 1'b0;
      vs    <= 1'b0;
      blank <= 1'b1;
      r     <= 8'h00;
      g     <= 8'h00;
      b     <= 8'h00;
    end else if (pce) begin
      hs    <= s1_hs;
      vs    <= s1_vs;
      blank <= s1_blank;
      if (s1_blank) begin
        r <= 8'h00;
        g <= 8'h00;
        b <= 8'h00;
      end else if (s1_par) begin
        r <= darken(s1_r, act_mode);
        g <= darken(s1_g, act_mode);
        b <= darken(s1_b, act_mode);
      end else begin
        r <= s1_r;
        g <= s1_g;
        b <= s1_b;
      end
    end
  end

endmodule

// File: tb/tb_lcd_scanline_fx.sv
// tb_lcd_scanline_fx: scoreboard bench for lcd_scanline_fx with a small reference model.
// Latency: expects each pixel two pce cycles after it is driven.
// Backpressure: none; pce gaps are inserted to check output hold.
module tb_lcd_scanline_fx;
  localparam int LCNT_W = 9;
  localparam int LW     = 12;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       blank;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pix_t;

  localparam pix_t RST_PIX = '{hs: 1'b0, vs: 1'b0, blank: 1'b1, r: 8'h00, g: 8'h00, b: 8'h00};

  logic              pclk = 1'b0;
  logic              reset = 1'b1;
  logic              pce = 1'b0;
  logic [1:0]        mode = 2'd0;
  logic              hs_in = 1'b0;
  logic              vs_in = 1'b0;
  logic              blank_in = 1'b1;
  logic [7:0]        r_in = 8'h00;
  logic [7:0]        g_in = 8'h00;
  logic [7:0]        b_in = 8'h00;
  logic              hs;
  logic              vs;
  logic              blank;
  logic [7:0]        r;
  logic [7:0]        g;
  logic [7:0]        b;
  logic [LCNT_W-1:0] frame_lines;
  logic              locked;

  always #5 pclk = ~pclk;

  lcd_scanline_fx #(.PIPE_LAT(2), .LCNT_W(LCNT_W)) dut (
    .pclk(pclk), .reset(reset), .pce(pce), .mode(mode),
    .hs_in(hs_in), .vs_in(vs_in), .blank_in(blank_in),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .hs(hs), .vs(vs), .blank(blank), .r(r), .g(g), .b(b),
    .frame_lines(frame_lines), .locked(locked)
  );

  int n_chk  = 0;
  int n_fail = 0;
  pix_t q[$];
  pix_t last_exp = RST_PIX;

  // reference model state
  logic              m_hsp, m_vsp, m_par, m_locked;
  logic [LCNT_W-1:0] m_lcnt, m_fl;
  logic [1:0]        m_mode;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] dk(input logic [7:0] x, input logic [1:0] m);
    case (m)
      2'd1:    return x - x / 8'd4;
      2'd2:    return x / 8'd2;
      2'd3:    return x / 8'd4;
      default: return x;
    endcase
  endfunction

  function automatic pix_t out_now();
    pix_t p;
    p = '{hs: hs, vs: vs, blank: blank, r: r, g: g, b: b};
    return p;
  endfunction

  task automatic model_reset();
    m_hsp = 1'b0; m_vsp = 1'b0; m_par = 1'b0; m_locked = 1'b0;
    m_lcnt = '0; m_fl = '0; m_mode = 2'd0;
    q.delete();
    last_exp = RST_PIX;
  endtask

  task automatic drive(input logic h, input logic v, input logic bl,
                       input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb);
    logic hr, vr, po;
    pix_t e;
    hs_in = h; vs_in = v; blank_in = bl; r_in = rr; g_in = gg; b_in = bb; pce = 1'b1;
    hr = h & ~m_hsp;
    vr = v & ~m_vsp;
    po = m_par;
    m_hsp = h;
    m_vsp = v;
    if (vr) begin
      m_locked = (m_lcnt == m_fl) && (m_fl != '0);
      m_fl     = m_lcnt;
      m_lcnt   = '0;
      m_par    = 1'b0;
      m_mode   = mode;
    end else if (hr) begin
      m_par = ~m_par;
      if (m_lcnt != {LCNT_W{1'b1}}) m_lcnt = m_lcnt + 1'b1;
    end
    e.hs = h; e.vs = v; e.blank = bl;
    e.r = bl ? 8'h00 : (po ? dk(rr, m_mode) : rr);
    e.g = bl ? 8'h00 : (po ? dk(gg, m_mode) : gg);
    e.b = bl ? 8'h00 : (po ? dk(bb, m_mode) : bb);
    q.push_back(e);
    @(posedge pclk); #1;
    if (q.size() == 2) begin
      last_exp = q.pop_front();
      chk("pix", 32'(out_now()), 32'(last_exp));
    end
    chk("frame_lines", 32'(frame_lines), 32'(m_fl));
    chk("locked", 32'(locked), 32'(m_locked));
  endtask

  task automatic idle(input int n);
    pce = 1'b0;
    for (int i = 0; i < n; i++) begin
      hs_in = 1'($urandom); vs_in = 1'($urandom); blank_in = 1'($urandom);
      r_in = 8'($urandom); g_in = 8'($urandom); b_in = 8'($urandom);
      @(posedge pclk); #1;
      chk("hold", 32'(out_now()), 32'(last_exp));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; pce = 1'b1;
    hs_in = 1'b1; vs_in = 1'b1; blank_in = 1'b0; r_in = 8'hFF; g_in = 8'hFF; b_in = 8'hFF;
    @(posedge pclk); #1;
    chk("rst_out", 32'(out_now()), 32'(RST_PIX));
    chk("rst_frame_lines", 32'(frame_lines), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    reset = 1'b0;
    pce = 1'b0;
    model_reset();
  endtask

  task automatic px(input logic [7:0] v);
    drive(1'b0, 1'b0, 1'b0, v, v, v);
  endtask

  task automatic vs_pulse();
    drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    drive(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
    drive(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
    drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic hs_pulse();
    drive(1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
  endtask

  // vsync rises mid-line so every line start, including the one before vsync, is an hs rise
  task automatic frame(input int nlines);
    int t;
    for (int l = 0; l < nlines; l++) begin
      for (int p = 0; p < LW; p++) begin
        t = l * LW + p;
        drive(p < 2, (t >= LW / 2) && (t < 3 * LW + LW / 2), (l < 5) || (p < 4),
              8'($urandom), 8'($urandom), 8'($urandom));
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] dexp;
    model_reset();
    @(posedge pclk); #1;
    do_reset();

    // latency and hold
    mode = 2'd0;
    drive(1'b0, 1'b0, 1'b0, 8'h80, 8'h40, 8'h20);
    chk("lat_early", 32'(out_now()), 32'(RST_PIX));
    idle(3);
    drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    chk("lat_rgb", {8'h0, r, g, b}, 32'h00804020);
    chk("lat_blank", 32'(blank), 32'd0);
    idle(4);

    // darken levels on an odd line, pass-through on the next even line
    for (int m = 1; m <= 3; m++) begin
      mode = 2'(m);
      dexp = (m == 1) ? 8'hC0 : (m == 2) ? 8'h7F : 8'h3F;
      vs_pulse();
      hs_pulse();
      px(8'hFF);
      px(8'h00);
      chk("dark_r", 32'(r), 32'(dexp));
      chk("dark_b", 32'(b), 32'(dexp));
      hs_pulse();
      px(8'hFF);
      px(8'h00);
      chk("even_r", 32'(r), 32'hFF);
    end

    // blank forcing on an odd line
    hs_pulse();
    drive(1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF);
    px(8'h00);
    chk("blank_rgb", {8'h0, r, g, b}, 32'h0);
    chk("blank_flag", 32'(blank), 32'd1);

    // mode change waits for the next vsync
    mode = 2'd0;
    vs_pulse();
    hs_pulse();
    mode = 2'd2;
    px(8'hFF);
    px(8'h00);
    chk("defer_same", 32'(r), 32'hFF);
    vs_pulse();
    hs_pulse();
    px(8'hFF);
    px(8'h00);
    chk("defer_next", 32'(r), 32'h7F);

    // simultaneous hs/vs rise: vsync wins, parity and count restart
    mode = 2'd3;
    vs_pulse();
    hs_pulse();
    drive(1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
    drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    px(8'hFF);
    px(8'h00);
    chk("simul_parity", 32'(r), 32'hFF);
    for (int i = 0; i < 5; i++) hs_pulse();
    vs_pulse();
    chk("simul_count", 32'(frame_lines), 32'd5);

    // line measurement and lock
    do_reset();
    mode = 2'd1;
    frame(263);
    mode = 2'd2;
    frame(263);
    chk("meas_263", 32'(frame_lines), 32'd263);
    chk("meas_lock0", 32'(locked), 32'd0);
    mode = 2'd3;
    frame(263);
    chk("meas_lock1", 32'(locked), 32'd1);
    idle(2);
    mode = 2'd0;
    frame(262);
    frame(263);
    chk("short_lines", 32'(frame_lines), 32'd262);
    chk("short_lock", 32'(locked), 32'd0);
    frame(263);
    frame(263);
    chk("relock", 32'(locked), 32'd1);

    // reset mid-line, then lock must wait for two complete matching frames
    hs_pulse();
    px(8'h55);
    px(8'hAA);
    do_reset();
    frame(263);
    frame(263);
    chk("post_rst_lock", 32'(locked), 32'd0);
    chk("post_rst_lines", 32'(frame_lines), 32'd263);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
